// File: rtl/grid_row_clear_if.sv
// Port bundle between the grid-update/scoring logic (master) and the row clearer (slave).
interface grid_row_clear_if #(
    parameter int COLS  = 4,
    parameter int ROWS  = 3,
    parameter int CNT_W = 4,
    parameter int TOT_W = 8
);
    logic                 load;
    logic [ROWS*COLS-1:0] ain;
    logic                 start;
    logic [ROWS*COLS-1:0] grid;
    logic [ROWS-1:0]      f;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     cleared;
    logic [TOT_W-1:0]     total;

    modport master (output load, ain, start,
                    input  grid, f, busy, done, cleared, total);
    modport slave  (input  load, ain, start,
                    output grid, f, busy, done, cleared, total);
endinterface

// File: rtl/grid_row_clear.sv
// Holds a ROWS x COLS occupancy grid; on start repeatedly removes the lowest-index full row
// and collapses the rows above it until no full row remains.
module grid_row_clear #(
    parameter int COLS  = 4,
    parameter int ROWS  = 3,
    parameter int CNT_W = 4,
    parameter int TOT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    grid_row_clear_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int KW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, CLEAR, DONE} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     grid_q, grid_shift;
    logic [ROWS-1:0]  f;
    logic [KW-1:0]    k_q, k_sel;
    logic             found;
    logic [CNT_W-1:0] cleared_q;
    logic [TOT_W-1:0] total_q;

    // Lowest-index full row wins; k_sel is its index.
    always_comb begin
        f     = '0;
        k_sel = '0;
        found = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (!found && (&grid_q[r*COLS +: COLS])) begin
                f[r]  = 1'b1;
                k_sel = KW'(r);
                found = 1'b1;
            end
        end
    end

    // Row k is dropped: rows 0..k-1 move down one, a blank row enters at the top.
    always_comb begin
        grid_shift = grid_q;
        for (int i = 0; i < ROWS; i++) begin
            if (i <= int'(k_q)) begin
                if (i == 0) grid_shift[i*COLS +: COLS] = '0;
                else        grid_shift[i*COLS +: COLS] = grid_q[(i-1)*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.load && bus.start) state_nxt = SCAN;
            SCAN:    state_nxt = (f != '0) ? CLEAR : DONE;
            CLEAR:   state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_q    <= '0;
            k_q       <= '0;
            cleared_q <= '0;
            total_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load)       grid_q    <= bus.ain;
                    else if (bus.start) cleared_q <= '0;
                end
                SCAN:  k_q <= k_sel;
                CLEAR: begin
                    grid_q    <= grid_shift;
                    cleared_q <= cleared_q + CNT_W'(1);
                    if (total_q != '1) total_q <= total_q + TOT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.grid    = grid_q;
    assign bus.f       = f;
    assign bus.busy    = (state == SCAN) || (state == CLEAR);
    assign bus.done    = (state == DONE);
    assign bus.cleared = cleared_q;
    assign bus.total   = total_q;
endmodule
